c5_bram_responder: RTL

//  Memory-bus responder for the soc CPU port (select/address/byte_we/data_write in; data_read/pause/data_ready out).

---
 rtl/c5_bram_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/c5_bram_responder.sv
// Block-RAM memory responder for the soc CPU port: fixed programmable latency plus refresh stalls.
// Optional access statistics counters are built when C5_MEM_STATS_EN is defined.
module c5_bram_responder #(
    parameter int ADDR_WIDTH     = 12,
    parameter int LATENCY        = 2,
    parameter int REFRESH_CYCLES = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_mem_select,
    input  logic [29:0] I_mem_address,
    input  logic [3:0]  I_mem_byte_we,
    input  logic [31:0] I_mem_data_write,
    output logic [31:0] O_mem_data_read,
    output logic        O_mem_pause,
    output logic        O_mem_data_ready,
    input  logic        I_refresh_req,
    output logic        O_busy
`ifdef C5_MEM_STATS_EN
    ,
    output logic [15:0] O_read_count,
    output logic [15:0] O_write_count,
    output logic [15:0] O_refresh_count
`endif
);

    localparam int         DEPTH        = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT_LOAD     = 4'(LATENCY - 1);
    localparam logic [3:0] REF_LOAD     = 4'(REFRESH_CYCLES - 1);
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_REFRESH = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    refresh_pending_reg;
    logic                    ready_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [3:0]              we_reg;

    logic                    refresh_due;
    logic                    accept;
    logic                    wr_en;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   ram_addr;

    assign refresh_due = refresh_pending_reg | I_refresh_req;
    assign accept      = (state_reg == ST_IDLE) && !refresh_due && I_mem_select;
    assign wr_en       = accept && (I_mem_byte_we != 4'b0000);

    // The RAM read is issued on the edge that enters the ready cycle, so the
    // registered read data lands exactly when the ready pulse is visible.
    assign rd_en = (accept && (I_mem_byte_we == 4'b0000) && SINGLE_CYCLE)
                 || ((state_reg == ST_ACCESS) && (cnt_reg == 4'd1) && (we_reg == 4'b0000));

    assign ram_addr = (state_reg == ST_IDLE) ? I_mem_address[ADDR_WIDTH-1:0] : addr_reg;

    generate
        if (ADDR_WIDTH < 30) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^I_mem_address[29:ADDR_WIDTH];
        end
    endgenerate

    // One RAM per byte lane keeps each lane a plain single-writer array.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge I_clk) begin
                if (wr_en && I_mem_byte_we[gi]) begin
                    lane_mem[ram_addr] <= I_mem_data_write[8*gi +: 8];
                end
            end

            always_ff @(posedge I_clk or posedge I_rst) begin
                if (I_rst) begin
                    lane_q <= 8'h00;
                end else if (rd_en) begin
                    lane_q <= lane_mem[ram_addr];
                end
            end

            assign O_mem_data_read[8*gi +: 8] = lane_q;
        end
    endgenerate

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_reg           <= ST_IDLE;
            cnt_reg             <= 4'd0;
            refresh_pending_reg <= 1'b0;
            ready_reg           <= 1'b0;
            addr_reg            <= '0;
            we_reg              <= 4'b0000;
        end else begin
            ready_reg <= 1'b0;
            if (I_refresh_req) begin
                refresh_pending_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (refresh_due) begin
                        // Refresh wins over a simultaneous CPU request.
                        state_reg           <= ST_REFRESH;
                        cnt_reg             <= REF_LOAD;
                        refresh_pending_reg <= 1'b0;
                    end else if (I_mem_select) begin
                        state_reg <= ST_ACCESS;
                        cnt_reg   <= LAT_LOAD;
                        addr_reg  <= I_mem_address[ADDR_WIDTH-1:0];
                        we_reg    <= I_mem_byte_we;
                        ready_reg <= SINGLE_CYCLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg   <= cnt_reg - 4'd1;
                        ready_reg <= (cnt_reg == 4'd1);
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_REFRESH: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        O_mem_pause = 1'b0;
        case (state_reg)
            ST_IDLE:    O_mem_pause = I_mem_select;
            ST_ACCESS:  O_mem_pause = (cnt_reg != 4'd0);
            ST_REFRESH: O_mem_pause = I_mem_select;
            default:    O_mem_pause = 1'b0;
        endcase
    end

    assign O_mem_data_ready = ready_reg;
    assign O_busy           = (state_reg != ST_IDLE);

`ifdef C5_MEM_STATS_EN
    logic [15:0] read_count_reg;
    logic [15:0] write_count_reg;
    logic [15:0] refresh_count_reg;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            read_count_reg    <= 16'd0;
            write_count_reg   <= 16'd0;
            refresh_count_reg <= 16'd0;
        end else begin
            if (ready_reg && (we_reg == 4'b0000)) begin
                read_count_reg <= read_count_reg + 16'd1;
            end
            if (ready_reg && (we_reg != 4'b0000)) begin
                write_count_reg <= write_count_reg + 16'd1;
            end
            if ((state_reg == ST_IDLE) && refresh_due) begin
                refresh_count_reg <= refresh_count_reg + 16'd1;
            end
        end
    end

    assign O_read_count    = read_count_reg;
    assign O_write_count   = write_count_reg;
    assign O_refresh_count = refresh_count_reg;
`endif

endmodule
